// File: rtl/usb_attach_ctrl.sv
// usb_attach_ctrl: delayed D+ pull-up attach, soft detach, suspend tracking and RGB status PWM
module usb_attach_ctrl #(
  parameter int TICK_DIV = 48,
  parameter int ATTACH_TICKS = 62500,
  parameter int ACTIVITY_TICKS = 3000,
  parameter int SYNC_STAGES = 2,
  parameter int LED_CHANNELS = 3,
  parameter int PWM_BITS = 8,
  parameter logic [LED_CHANNELS*PWM_BITS-1:0] COLOR_DETACHED = {8'h00, 8'h00, 8'h40},
  parameter logic [LED_CHANNELS*PWM_BITS-1:0] COLOR_ATTACHED = {8'h00, 8'h40, 8'h00},
  parameter logic [LED_CHANNELS*PWM_BITS-1:0] COLOR_SUSPENDED = {8'h10, 8'h00, 8'h00},
  parameter logic [LED_CHANNELS*PWM_BITS-1:0] COLOR_ACTIVITY = {8'h00, 8'hFF, 8'h00}
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    detach_i,
  input  logic                    sleep_i,
  input  logic                    activity_i,
  output logic                    usb_dp_pu_o,
  output logic [1:0]              state_o,
  output logic [LED_CHANNELS-1:0] led_o
);
  localparam int TW = $clog2(TICK_DIV);
  localparam int AW = $clog2(ATTACH_TICKS + 1);
  localparam int CW = ACTIVITY_TICKS > 0 ? $clog2(ACTIVITY_TICKS + 1) : 1;
  typedef enum logic [1:0] {DETACHED = 2'd0, ATTACHED = 2'd1, SUSPENDED = 2'd2} state_t;
  state_t state_q, state_d;
  logic [TW-1:0] tick_cnt;
  logic tick;
  logic [SYNC_STAGES-1:0] sync_q;
  logic sleep_s;
  logic [AW-1:0] att_q, att_d;
  logic [CW-1:0] act_q, act_d;
  logic [PWM_BITS-1:0] pwm_cnt;
  logic [LED_CHANNELS*PWM_BITS-1:0] duty;
  logic [LED_CHANNELS-1:0] led_d;
  assign tick = tick_cnt == TW'(TICK_DIV - 1);
  assign sleep_s = sync_q[SYNC_STAGES-1];
  assign state_o = state_q;
  always_comb begin
    state_d = state_q;
    att_d = att_q;
    case (state_q)
      DETACHED:
        if (detach_i) att_d = '0;
        else if (tick) begin
          if (att_q == AW'(ATTACH_TICKS - 1)) state_d = ATTACHED;
          else att_d = att_q + 1'b1;
        end
      ATTACHED: begin
        state_d = detach_i ? DETACHED : sleep_s ? SUSPENDED : ATTACHED;
        att_d = detach_i ? '0 : att_q;
      end
      SUSPENDED: begin
        state_d = detach_i ? DETACHED : !sleep_s ? ATTACHED : SUSPENDED;
        att_d = detach_i ? '0 : att_q;
      end
      default: begin
        state_d = DETACHED;
        att_d = '0;
      end
    endcase
    act_d = (state_q != ATTACHED || state_d != ATTACHED) ? '0 :
            activity_i ? CW'(ACTIVITY_TICKS) :
            (tick && act_q != '0) ? act_q - 1'b1 : act_q;
    duty = (state_q == ATTACHED && act_q != '0) ? COLOR_ACTIVITY :
           state_q == ATTACHED ? COLOR_ATTACHED :
           state_q == SUSPENDED ? COLOR_SUSPENDED : COLOR_DETACHED;
  end
  for (genvar k = 0; k < LED_CHANNELS; k++) begin : g_pwm
    assign led_d[k] = pwm_cnt < duty[k*PWM_BITS +: PWM_BITS];
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      tick_cnt <= '0;
      sync_q <= '0;
      state_q <= DETACHED;
      att_q <= '0;
      act_q <= '0;
      pwm_cnt <= '0;
      usb_dp_pu_o <= 1'b0;
      led_o <= '0;
    end else begin
      tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
      sync_q <= {sync_q[SYNC_STAGES-2:0], sleep_i};
      state_q <= state_d;
      att_q <= att_d;
      act_q <= act_d;
      pwm_cnt <= pwm_cnt + 1'b1;
      usb_dp_pu_o <= state_d != DETACHED;
      led_o <= led_d;
    end
  end
endmodule

// File: tb/tb_usb_attach_ctrl.sv
// tb_usb_attach_ctrl: directed and randomized checks against a timing-based reference model
module tb_usb_attach_ctrl;
  localparam int TD = 4, AT = 5, ACT = 3;
  localparam logic [23:0] C_DET = 24'h000040, C_ATT = 24'h004000, C_SUS = 24'h100000, C_ACT = 24'h00FF00;
  logic clk = 0, rst = 1, det = 0, slp = 0, actv = 0;
  logic pu;
  logic [1:0] st;
  logic [2:0] led;
  int checks = 0, errors = 0;
  int n, m_st, m_att, m_act;
  bit m_pu;
  logic [2:0] m_led;
  bit s_q[$];
  usb_attach_ctrl #(.TICK_DIV(TD), .ATTACH_TICKS(AT), .ACTIVITY_TICKS(ACT), .SYNC_STAGES(2),
    .LED_CHANNELS(3), .PWM_BITS(8)) dut (
    .clk_i(clk), .rst_i(rst), .detach_i(det), .sleep_i(slp), .activity_i(actv),
    .usb_dp_pu_o(pu), .state_o(st), .led_o(led));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h at %0t", tag, got, exp, $time);
    end
  endtask
  function automatic logic [23:0] duty_of(input int s, input int a);
    return (s == 1 && a > 0) ? C_ACT : s == 1 ? C_ATT : s == 2 ? C_SUS : C_DET;
  endfunction
  task automatic model_edge();
    logic [23:0] d;
    bit tk, ss;
    int ns;
    if (rst) begin
      n = 0; m_st = 0; m_att = 0; m_act = 0; m_pu = 0; m_led = '0;
      s_q.delete();
      repeat (2) s_q.push_back(1'b0);
      return;
    end
    d = duty_of(m_st, m_act);
    n++;
    tk = (n % TD) == 0;
    ss = s_q.pop_front();
    s_q.push_back(slp);
    for (int k = 0; k < 3; k++) m_led[k] = ((n - 1) % 256) < int'(d[k*8 +: 8]);
    ns = m_st;
    if (det) begin
      ns = 0;
      m_att = 0;
    end else if (m_st == 0) begin
      if (tk) m_att++;
      if (m_att == AT) ns = 1;
    end else ns = ss ? 2 : 1;
    m_act = (m_st == 1 && ns == 1) ? (actv ? ACT : (tk && m_act > 0) ? m_act - 1 : m_act) : 0;
    m_st = ns;
    m_pu = m_st != 0;
  endtask
  task automatic cyc();
    @(posedge clk);
    model_edge();
    #1;
    chk("state", st, m_st);
    chk("pu", pu, m_pu);
    chk("led", led, m_led);
  endtask
  task automatic count256(input string tag, input logic [23:0] exp);
    int c[3];
    c = '{0, 0, 0};
    repeat (256) begin
      cyc();
      for (int k = 0; k < 3; k++) c[k] += int'(led[k]);
    end
    for (int k = 0; k < 3; k++) chk($sformatf("%s_ch%0d", tag, k), c[k], exp[k*8 +: 8]);
  endtask
  initial begin
    rst = 1;
    repeat (2) cyc();
    chk("rst_pu", pu, 0);
    chk("rst_led", led, 0);
    rst = 0;
    repeat (19) cyc();
    chk("t1_early_pu", pu, 0);
    cyc();
    chk("t1_pu", pu, 1);
    chk("t1_state", st, 1);
    count256("pwm_att", C_ATT);
    slp = 1;
    repeat (2) cyc();
    chk("t3_still_att", st, 1);
    cyc();
    chk("t3_susp", st, 2);
    chk("t3_pu", pu, 1);
    count256("pwm_sus", C_SUS);
    slp = 0;
    repeat (3) cyc();
    chk("t3_back", st, 1);
    actv = 1;
    cyc();
    actv = 0;
    cyc();
    chk("t4_act_ch1", led[1], 1);
    repeat (20) cyc();
    det = 1;
    cyc();
    chk("det_state", st, 0);
    count256("pwm_det", C_DET);
    repeat (4) cyc();
    det = 0;
    repeat (30) cyc();
    chk("t2_reattach", st, 1);
    actv = 1;
    cyc();
    actv = 0;
    slp = 1;
    repeat (3) cyc();
    rst = 1;
    cyc();
    chk("t6_pu", pu, 0);
    chk("t6_state", st, 0);
    chk("t6_led", led, 0);
    rst = 0;
    slp = 0;
    repeat (20) cyc();
    chk("t6_reattach", st, 1);
    repeat (6000) begin
      if ($urandom_range(0, 199) == 0) det = ~det;
      if ($urandom_range(0, 39) == 0) slp = ~slp;
      actv = $urandom_range(0, 7) == 0;
      rst = $urandom_range(0, 999) == 0;
      cyc();
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
